active_list_retire: RTL and testbench
=====================================

Name: active_list_retire

Overview:
In-order retirement and rollback engine for the renamed out-of-order core. It is the consumer end of the rename stage's allocation stream: it records each (arch reg, new phys, old phys) mapping, marks entries done on writeback, and retires them in program order. On retire it returns old physical registers to the free list; on mispredict it walks back younger entries, restoring RMT mappings and freeing their new physical registers.

Parameters:
AL_DEPTH, 32, number of active-list entries (power of 2)
TAG_W, 5, log2(AL_DEPTH); entry index width
PHYS_W, 6, physical register index width (64 phys regs)
ARCH_W, 5, architectural register index width (32 arch regs)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
alloc_valid  input  1  rename presents an instruction
alloc_ready  output  1  entry can be accepted this cycle
alloc_uses_rw  input  1  instruction writes a register
alloc_arch  input  ARCH_W  destination arch reg
alloc_new_phys  input  PHYS_W  phys reg taken from free list
alloc_old_phys  input  PHYS_W  previous RMT mapping
alloc_tag  output  TAG_W  index assigned to the presented instruction (= tail)
wb_valid  input  1  execution completed
wb_tag  input  TAG_W  tag of completed instruction
mispredict_valid  input  1  branch mispredicted
mispredict_tag  input  TAG_W  tag of mispredicted branch; younger entries squashed
commit_valid  output  1  one instruction retired
commit_tag  output  TAG_W  tag retired
free_valid  output  1  return phys reg to free list
free_phys  output  PHYS_W  phys reg returned
rmt_restore_valid  output  1  write RMT entry
rmt_restore_arch  output  ARCH_W  arch reg to restore
rmt_restore_phys  output  PHYS_W  mapping to restore
rollback_busy  output  1  rollback in progress
empty  output  1  no valid entries
full  output  1  AL_DEPTH valid entries

Behaviour:
- Storage per entry: valid, done, uses_rw, arch, new_phys, old_phys. Head/tail pointers TAG_W+1 bits (wrap bit); full = same index with different wrap bit; empty = pointers equal.
- Reset (async): head=tail=0, all valid/done=0, state RUN. All registered outputs 0. Combinational outputs after reset: alloc_ready=1, empty=1, full=0, alloc_tag=0. Reset mid-rollback discards everything and returns to RUN.
- States: RUN, ROLLBACK.
- Allocate: accept when alloc_valid && alloc_ready; alloc_ready = (state==RUN) && !full. On accept, write entry at tail with done=0 and advance tail (wraps AL_DEPTH-1 -> 0).
- Writeback: wb_valid sets done[wb_tag] only if valid[wb_tag]; otherwise ignored. Accepted in both states.
- Commit (RUN only): if head entry is valid && done at a clock edge, then at that edge: commit_valid<=1, commit_tag<=head, free_valid<=uses_rw, free_phys<=old_phys, clear valid, head++. One retire per cycle. Latency: wb at edge N -> commit outputs high after edge N+1. Otherwise commit_valid/free_valid<=0.
- Alloc and commit in the same cycle are both performed. Alloc into the slot being freed while full is not possible: alloc_ready already low.
- Mispredict in RUN: ignored if the tag is not a valid entry. If the tag is the youngest entry (tail-1), there is nothing to squash and the block stays in RUN. Otherwise target=tag+1 and the block enters ROLLBACK at the next edge. An alloc presented in the same cycle is not accepted: alloc_ready is forced 0 when mispredict_valid is high.
- ROLLBACK, one entry per cycle from tail-1 toward target:
  - rmt_restore_valid<=uses_rw, rmt_restore_arch<=arch, rmt_restore_phys<=old_phys.
  - free_valid<=uses_rw, free_phys<=new_phys.
  - Clear valid and done; tail--.
  - When the entry at target has been popped (tail reaches target), go to RUN.
  - No commits during rollback.
  - rollback_busy=1 throughout ROLLBACK.
- Mispredict during ROLLBACK: if its tag is valid and older than the current target (closer to head), target=tag+1. Otherwise it is ignored.
- The mispredicting branch itself is never squashed; it commits normally.

Optional Feature:
AL_PERF_CNT_EN: when defined, adds outputs perf_commits (32-bit, increments per commit) and perf_squashes (32-bit, increments per entry popped in ROLLBACK). Both reset to 0 and wrap at 2^32. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset -> empty=1, alloc_ready=1, commit_valid=free_valid=rmt_restore_valid=0, alloc_tag=0.
- Alloc 3 entries (arch 1/2/3, new 32/33/34, old 1/2/3), wb tags 2,0,1 -> commits in order tags 0,1,2 with free_phys 1,2,3 on consecutive cycles. No commit before tag 0 is done.
- Alloc 32 entries without wb -> full=1, alloc_ready=0. Then wb tag 0 -> one commit, full=0. Next alloc gets alloc_tag=0 (wrap).
- Alloc tags 0..5 (all uses_rw), mispredict_tag=2 -> 3 rollback cycles popping tags 5,4,3, each restoring arch/old_phys and freeing new_phys. rollback_busy high 3 cycles. Next alloc_tag=3.
- During rollback toward target 4, mispredict_tag=1 -> rollback continues to tag 2. Mispredict_tag=7 (invalid entry) -> ignored.
- Assert rst_n mid-rollback -> all outputs 0, empty=1, state RUN. With AL_PERF_CNT_EN defined, perf counters read 0.

Source files
------------

// File: rtl/active_list_retire.sv
// In-order retirement and mispredict rollback engine for the renamed OoO core.
// Optional perf counters are built when AL_PERF_CNT_EN is defined.
module active_list_retire #(
  parameter int AL_DEPTH = 32,
  parameter int TAG_W    = 5,
  parameter int PHYS_W   = 6,
  parameter int ARCH_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_uses_rw,
  input  logic [ARCH_W-1:0] alloc_arch,
  input  logic [PHYS_W-1:0] alloc_new_phys,
  input  logic [PHYS_W-1:0] alloc_old_phys,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              mispredict_valid,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              free_valid,
  output logic [PHYS_W-1:0] free_phys,
  output logic              rmt_restore_valid,
  output logic [ARCH_W-1:0] rmt_restore_arch,
  output logic [PHYS_W-1:0] rmt_restore_phys,
  output logic              rollback_busy,
  output logic              empty,
  output logic              full
`ifdef AL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_commits,
  output logic [31:0]       perf_squashes
`endif
);

  typedef enum logic {RUN = 1'b0, ROLLBACK = 1'b1} state_t;

  localparam logic [TAG_W:0] PTR_ONE = 1;

  state_t           state, state_next;
  logic [TAG_W:0]   head, tail, tail_m1;
  logic [TAG_W:0]   target, target_next;
  logic [TAG_W-1:0] head_idx, tail_idx, pop_idx;
  logic [TAG_W:0]   mp_off, tgt_off, mp_target;
  logic             mp_hit, mp_youngest;
  logic             commit_fire, alloc_fire, pop_fire;

  logic [AL_DEPTH-1:0] valid, done;
  logic                uses_rw_mem  [AL_DEPTH];
  logic [ARCH_W-1:0]   arch_mem     [AL_DEPTH];
  logic [PHYS_W-1:0]   new_phys_mem [AL_DEPTH];
  logic [PHYS_W-1:0]   old_phys_mem [AL_DEPTH];

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign tail_m1  = tail - PTR_ONE;
  assign pop_idx  = tail_m1[TAG_W-1:0];

  // Ages are measured as distance from head so wrapped tags compare correctly.
  assign mp_off    = {1'b0, mispredict_tag - head_idx};
  assign tgt_off   = target - head;
  assign mp_target = head + mp_off + PTR_ONE;

  assign mp_hit      = mispredict_valid && valid[mispredict_tag];
  assign mp_youngest = (mispredict_tag == pop_idx);
  assign commit_fire = (state == RUN) && valid[head_idx] && done[head_idx];
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign pop_fire    = (state == ROLLBACK);

  assign empty     = (head == tail);
  assign full      = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign alloc_tag = tail_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      target <= '0;
    end else begin
      state  <= state_next;
      target <= target_next;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    target_next = target;
    case (state)
      RUN: begin
        if (mp_hit && !mp_youngest) begin
          state_next  = ROLLBACK;
          target_next = mp_target;
        end
      end
      ROLLBACK: begin
        if (mp_hit && (mp_off < tgt_off))
          target_next = mp_target;
        if (tail_m1 == target_next)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    alloc_ready   = (state == RUN) && !full && !mispredict_valid;
    rollback_busy = (state == ROLLBACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (wb_valid && valid[wb_tag])
        done[wb_tag] <= 1'b1;
      if (alloc_fire) begin
        valid[tail_idx] <= 1'b1;
        done[tail_idx]  <= 1'b0;
        tail            <= tail + PTR_ONE;
      end
      if (commit_fire) begin
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
        head            <= head + PTR_ONE;
      end
      if (pop_fire) begin
        valid[pop_idx] <= 1'b0;
        done[pop_idx]  <= 1'b0;
        tail           <= tail_m1;
      end
    end
  end

  // NOTE: payload storage has no reset; valid bits alone decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      uses_rw_mem[tail_idx]  <= alloc_uses_rw;
      arch_mem[tail_idx]     <= alloc_arch;
      new_phys_mem[tail_idx] <= alloc_new_phys;
      old_phys_mem[tail_idx] <= alloc_old_phys;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid      <= 1'b0;
      commit_tag        <= '0;
      free_valid        <= 1'b0;
      free_phys         <= '0;
      rmt_restore_valid <= 1'b0;
      rmt_restore_arch  <= '0;
      rmt_restore_phys  <= '0;
    end else begin
      commit_valid      <= commit_fire;
      free_valid        <= 1'b0;
      rmt_restore_valid <= 1'b0;
      if (commit_fire) begin
        commit_tag <= head_idx;
        free_valid <= uses_rw_mem[head_idx];
        free_phys  <= old_phys_mem[head_idx];
      end
      // Commit and rollback pop are mutually exclusive, so free_* has one source per cycle.
      if (pop_fire) begin
        rmt_restore_valid <= uses_rw_mem[pop_idx];
        rmt_restore_arch  <= arch_mem[pop_idx];
        rmt_restore_phys  <= old_phys_mem[pop_idx];
        free_valid        <= uses_rw_mem[pop_idx];
        free_phys         <= new_phys_mem[pop_idx];
      end
    end
  end

`ifdef AL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_commits  <= '0;
      perf_squashes <= '0;
    end else begin
      if (commit_fire) perf_commits  <= perf_commits + 32'd1;
      if (pop_fire)    perf_squashes <= perf_squashes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_active_list_retire.sv
// Randomized self-checking bench for active_list_retire against a queue-based
// model of the active list (entries in program order, rollback as "keep N").
module tb_active_list_retire;
  localparam int D = 32, TW = 5, PW = 6, AW = 5;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          alloc_valid = 0, alloc_ready, alloc_uses_rw = 0;
  logic [AW-1:0] alloc_arch = '0;
  logic [PW-1:0] alloc_new_phys = '0, alloc_old_phys = '0;
  logic [TW-1:0] alloc_tag;
  logic          wb_valid = 0;
  logic [TW-1:0] wb_tag = '0;
  logic          mispredict_valid = 0;
  logic [TW-1:0] mispredict_tag = '0;
  logic          commit_valid, free_valid, rmt_restore_valid, rollback_busy, empty, full;
  logic [TW-1:0] commit_tag;
  logic [PW-1:0] free_phys, rmt_restore_phys;
  logic [AW-1:0] rmt_restore_arch;
`ifdef AL_PERF_CNT_EN
  logic [31:0]   perf_commits, perf_squashes;
`endif

  always #5 clk = ~clk;

  active_list_retire dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_uses_rw(alloc_uses_rw),
    .alloc_arch(alloc_arch), .alloc_new_phys(alloc_new_phys), .alloc_old_phys(alloc_old_phys),
    .alloc_tag(alloc_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .free_valid(free_valid), .free_phys(free_phys),
    .rmt_restore_valid(rmt_restore_valid), .rmt_restore_arch(rmt_restore_arch),
    .rmt_restore_phys(rmt_restore_phys), .rollback_busy(rollback_busy),
    .empty(empty), .full(full)
`ifdef AL_PERF_CNT_EN
    , .perf_commits(perf_commits), .perf_squashes(perf_squashes)
`endif
  );

  typedef struct {
    int tag; bit urw; int arch; int newp; int oldp; bit done;
  } ent_t;

  ent_t al[$];
  int   head_tag, keep;
  bit   rolling;
  bit   e_cv, e_fv, e_rv;
  int   e_ct, e_fp, e_ra, e_rp, e_pc, e_ps;
  int   n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_pos(input int tag);
    foreach (al[i]) if (al[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic int pick_tag();
    if (al.size() > 0 && ($urandom % 8) != 0) return al[$urandom % al.size()].tag;
    return int'($urandom % D);
  endfunction

  task automatic model_reset();
    al.delete();
    head_tag = 0; keep = 0; rolling = 0;
    e_cv = 0; e_fv = 0; e_rv = 0; e_ct = 0; e_fp = 0; e_ra = 0; e_rp = 0;
    e_pc = 0; e_ps = 0;
  endtask

  task automatic check_outputs();
    check("empty", empty, al.size() == 0);
    check("full", full, al.size() == D);
    check("rollback_busy", rollback_busy, rolling);
    check("commit_valid", commit_valid, e_cv);
    if (e_cv) check("commit_tag", commit_tag, e_ct);
    check("free_valid", free_valid, e_fv);
    if (e_fv) check("free_phys", free_phys, e_fp);
    check("rmt_restore_valid", rmt_restore_valid, e_rv);
    if (e_rv) begin
      check("rmt_restore_arch", rmt_restore_arch, e_ra);
      check("rmt_restore_phys", rmt_restore_phys, e_rp);
    end
`ifdef AL_PERF_CNT_EN
    check("perf_commits", perf_commits, e_pc);
    check("perf_squashes", perf_squashes, e_ps);
`endif
  endtask

  // One clock cycle: check state left by the previous edge, drive, then advance the model.
  task automatic step(input bit av, input bit urw, input int ar, input int np, input int op,
                      input bit wv, input int wt, input bit mv, input int mt);
    bit   ready, cfire;
    int   atag, mpos, presize, p;
    ent_t ent;
    @(negedge clk);
    check_outputs();
    alloc_valid = av; alloc_uses_rw = urw;
    alloc_arch = AW'(ar); alloc_new_phys = PW'(np); alloc_old_phys = PW'(op);
    wb_valid = wv; wb_tag = TW'(wt);
    mispredict_valid = mv; mispredict_tag = TW'(mt);
    #1;
    presize = al.size();
    ready = !rolling && presize < D && !mv;
    atag  = (head_tag + presize) % D;
    check("alloc_ready", alloc_ready, ready);
    check("alloc_tag", alloc_tag, atag);

    mpos  = mv ? find_pos(mt) : -1;
    cfire = !rolling && presize > 0 && al[0].done;
    e_cv = 0; e_fv = 0; e_rv = 0;
    if (cfire) begin
      ent = al.pop_front();
      e_cv = 1; e_ct = ent.tag; e_fv = ent.urw; e_fp = ent.oldp;
      head_tag = (head_tag + 1) % D;
      e_pc++;
    end
    if (wv) begin
      p = find_pos(wt);
      if (p >= 0) al[p].done = 1;
    end
    if (av && ready) al.push_back('{atag, urw, ar, np, op, 1'b0});
    if (!rolling) begin
      if (mpos >= 0 && mpos != presize - 1) begin
        rolling = 1;
        keep = mpos + 1 - int'(cfire);
      end
    end else begin
      if (mpos >= 0 && mpos < keep) keep = mpos + 1;
      ent = al.pop_back();
      e_rv = ent.urw; e_ra = ent.arch; e_rp = ent.oldp;
      e_fv = ent.urw; e_fp = ent.newp;
      e_ps++;
      if (al.size() == keep) rolling = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc1(input int ar, input int np, input int op);
    step(1, 1, ar, np, op, 0, 0, 0, 0);
  endtask

  // Reset is asserted asynchronously mid-cycle, outputs checked while it is held.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    alloc_valid = 0; wb_valid = 0; mispredict_valid = 0;
    #1;
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_tag", commit_tag, 0);
    check("rst_free_valid", free_valid, 0);
    check("rst_free_phys", free_phys, 0);
    check("rst_rmt_valid", rmt_restore_valid, 0);
    check("rst_rmt_arch", rmt_restore_arch, 0);
    check("rst_rmt_phys", rmt_restore_phys, 0);
    check("rst_rollback_busy", rollback_busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_tag", alloc_tag, 0);
`ifdef AL_PERF_CNT_EN
    check("rst_perf_commits", perf_commits, 0);
    check("rst_perf_squashes", perf_squashes, 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // In-order commit despite out-of-order writeback.
    for (int i = 0; i < 3; i++) alloc1(i + 1, 32 + i, i + 1);
    step(0, 0, 0, 0, 0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(4);

    // Fill to full, retire one, wrap the tail.
    do_reset();
    for (int i = 0; i < D; i++) alloc1(i % 32, 32 + (i % 32), i % 32);
    step(1, 1, 5, 5, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    alloc1(9, 40, 9);
    idle(2);

    // Simple rollback: squash tags 5,4,3.
    do_reset();
    for (int i = 0; i < 6; i++) alloc1(i + 1, 32 + i, i + 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 2);
    idle(4);
    alloc1(20, 50, 20);
    idle(2);

    // Nested mispredict retargets the rollback; stale tag ignored.
    do_reset();
    for (int i = 0; i < 8; i++) alloc1(i + 1, 32 + i, i + 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    idle(8);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit av, wv, mv;
      av = ($urandom % 100) < 60;
      wv = ($urandom % 100) < 50;
      mv = ($urandom % 100) < 4;
      step(av, 1'($urandom), int'($urandom % 32), int'($urandom % 64), int'($urandom % 64),
           wv, pick_tag(), mv, pick_tag());
    end

    // Reset in the middle of a rollback.
    do_reset();
    for (int i = 0; i < 10; i++) alloc1(i + 1, 32 + i, i + 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    do_reset();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
